// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    localparam int unsigned HZ_RA_W   = 5;
    localparam int unsigned HZ_X0_IDX = 0;
    localparam int unsigned HZ_CNT_W  = 2;
    localparam int unsigned HZ_ST_W   = 2;

    typedef enum logic [HZ_ST_W-1:0] {
        ST_RUN      = 2'd0,
        ST_LD_WAIT  = 2'd1,
        ST_MDU_WAIT = 2'd2
    } hz_state_t;

endpackage

// File: rtl/gen_en_dff.sv
// Generic enabled register with synchronous active-high reset.
module gen_en_dff #(
    parameter int unsigned     W       = 1,
    parameter logic [W-1:0]    RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    // Capture on enable, reset to RST_VAL.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_q <= RST_VAL;
        end else if (i_en) begin
            o_q <= i_d;
        end
    end

endmodule

// File: rtl/hazard_fwd_match.sv
// Per-source forwarding match: youngest-stage one-hot select and stage-0 hit.
module hazard_fwd_match
    import hazard_pkg::*;
#(
    parameter int unsigned FWD_STAGES = 2,
    parameter int unsigned RA_W       = HZ_RA_W
) (
    input  logic [RA_W-1:0]            i_rs_addr,
    input  logic                       i_rs_ren,
    input  logic [FWD_STAGES*RA_W-1:0] i_rd_addr,
    input  logic [FWD_STAGES-1:0]      i_rd_wen,
    output logic [FWD_STAGES-1:0]      o_sel_c,
    output logic                       o_hit0_c
);

    localparam logic [RA_W-1:0] X0_ADDR = RA_W'(HZ_X0_IDX);

    logic [FWD_STAGES-1:0] w_hit;
    logic                  w_src_live;

    // x0 is hardwired zero and never forwards.
    assign w_src_live = i_rs_ren && (i_rs_addr != X0_ADDR);

    genvar gk;
    for (gk = 0; gk < FWD_STAGES; gk++) begin : g_stage
        assign w_hit[gk] = w_src_live && i_rd_wen[gk]
                           && (i_rd_addr[gk*RA_W +: RA_W] == i_rs_addr);
    end

    // Lowest set bit isolates the youngest matching stage.
    assign o_sel_c  = w_hit & (~w_hit + FWD_STAGES'(1));
    assign o_hit0_c = w_hit[0];

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, load-use and MDU stall
// sequencing, redirect flushes. Optional MDU wait support: HAZARD_MDU_EN.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned FWD_STAGES = 2,
    parameter int unsigned LOAD_LAT   = 1,
    parameter int unsigned RA_W       = HZ_RA_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC*RA_W-1:0]       id_rs_addr,
    input  logic [NUM_SRC-1:0]            id_rs_ren,
    input  logic [FWD_STAGES*RA_W-1:0]    fwd_rd_addr,
    input  logic [FWD_STAGES-1:0]         fwd_rd_wen,
    input  logic                          ex_is_load,
    input  logic                          ex_jump,
    input  logic                          ex_mdu_start,
    input  logic                          mdu_done,
    output logic [NUM_SRC*FWD_STAGES-1:0] ex_fwd_sel,
    output logic                          stall_f,
    output logic                          stall_d,
    output logic                          stall_e,
    output logic                          flush_d,
    output logic                          flush_e,
    output logic                          bubble_m
);

    localparam int unsigned CNT_W  = HZ_CNT_W;
    localparam int unsigned SEL_W  = NUM_SRC * FWD_STAGES;
    localparam logic [CNT_W-1:0] LD_INIT = CNT_W'(LOAD_LAT - 1);

    logic [SEL_W-1:0]   w_id_sel;
    logic [NUM_SRC-1:0] w_hit0;
    logic               w_any_hit0;
    logic               w_post_rst;
    logic               w_mask;
    logic [HZ_ST_W-1:0] w_state_q;
    hz_state_t          w_state;
    hz_state_t          w_nxt_state;
    logic [CNT_W-1:0]   w_cnt;
    logic [CNT_W-1:0]   w_nxt_cnt;
    logic [CNT_W-1:0]   w_cnt_dec;
    logic               w_sel_en;
    logic [SEL_W-1:0]   w_sel_d;

    // One matcher per source operand.
    genvar gi;
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
        hazard_fwd_match #(
            .FWD_STAGES (FWD_STAGES),
            .RA_W       (RA_W)
        ) u_match (
            .i_rs_addr (id_rs_addr[gi*RA_W +: RA_W]),
            .i_rs_ren  (id_rs_ren[gi]),
            .i_rd_addr (fwd_rd_addr),
            .i_rd_wen  (fwd_rd_wen),
            .o_sel_c   (w_id_sel[gi*FWD_STAGES +: FWD_STAGES]),
            .o_hit0_c  (w_hit0[gi])
        );
    end

    assign w_any_hit0 = |w_hit0;
    assign w_state    = hz_state_t'(w_state_q);
    assign w_cnt_dec  = w_cnt - CNT_W'(1);

    // Flags the first cycle after reset so control outputs stay quiet there.
    gen_en_dff #(.W(1), .RST_VAL(1'b1)) u_post_rst (
        .clk  (clk),
        .rst  (rst),
        .i_en (1'b1),
        .i_d  (1'b0),
        .o_q  (w_post_rst)
    );

    assign w_mask = rst | w_post_rst;

    // FSM state register.
    gen_en_dff #(.W(HZ_ST_W), .RST_VAL(ST_RUN)) u_state (
        .clk  (clk),
        .rst  (rst),
        .i_en (1'b1),
        .i_d  (w_nxt_state),
        .o_q  (w_state_q)
    );

    // Load-use bubble counter.
    gen_en_dff #(.W(CNT_W), .RST_VAL('0)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .i_en (1'b1),
        .i_d  (w_nxt_cnt),
        .o_q  (w_cnt)
    );

    // Next-state and same-cycle stall/flush controls.
    always_comb begin
        w_nxt_state = w_state;
        w_nxt_cnt   = w_cnt;
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        stall_e     = 1'b0;
        flush_d     = 1'b0;
        flush_e     = 1'b0;
        bubble_m    = 1'b0;
        if (!w_mask) begin
            case (w_state)
                ST_RUN: begin
                    if (ex_jump) begin
                        flush_d   = 1'b1;
                        flush_e   = 1'b1;
                        w_nxt_cnt = '0;
                    end else if (ex_is_load && w_any_hit0) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        flush_e = 1'b1;
                        if (LOAD_LAT > 1) begin
                            w_nxt_state = ST_LD_WAIT;
                            w_nxt_cnt   = LD_INIT;
                        end
                    end
`ifdef HAZARD_MDU_EN
                    else if (ex_mdu_start && !mdu_done) begin
                        stall_f     = 1'b1;
                        stall_d     = 1'b1;
                        stall_e     = 1'b1;
                        bubble_m    = 1'b1;
                        w_nxt_state = ST_MDU_WAIT;
                    end
`endif
                end
                ST_LD_WAIT: begin
                    if (ex_jump) begin
                        flush_d     = 1'b1;
                        flush_e     = 1'b1;
                        w_nxt_state = ST_RUN;
                        w_nxt_cnt   = '0;
                    end else begin
                        stall_f   = 1'b1;
                        stall_d   = 1'b1;
                        flush_e   = 1'b1;
                        w_nxt_cnt = w_cnt_dec;
                        if (w_cnt_dec == '0) begin
                            w_nxt_state = ST_RUN;
                        end
                    end
                end
`ifdef HAZARD_MDU_EN
                ST_MDU_WAIT: begin
                    if (mdu_done) begin
                        w_nxt_state = ST_RUN;
                    end else begin
                        stall_f  = 1'b1;
                        stall_d  = 1'b1;
                        stall_e  = 1'b1;
                        bubble_m = 1'b1;
                    end
                end
`endif
                default: begin
                    w_nxt_state = ST_RUN;
                    w_nxt_cnt   = '0;
                end
            endcase
        end
    end

`ifndef HAZARD_MDU_EN
    logic w_unused_mdu;
    assign w_unused_mdu = ex_mdu_start ^ mdu_done;
`endif

    // Execute-stage forward select: clear on flush, hold on stall.
    assign w_sel_en = flush_e | ~stall_e;
    assign w_sel_d  = flush_e ? '0 : w_id_sel;

    gen_en_dff #(.W(SEL_W), .RST_VAL('0)) u_ex_sel (
        .clk  (clk),
        .rst  (rst),
        .i_en (w_sel_en),
        .i_d  (w_sel_d),
        .o_q  (ex_fwd_sel)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (NUM_SRC=2, FWD_STAGES=2, LOAD_LAT=2).
module tb_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic [9:0]  id_rs_addr;
    logic [1:0]  id_rs_ren;
    logic [9:0]  fwd_rd_addr;
    logic [1:0]  fwd_rd_wen;
    logic        ex_is_load;
    logic        ex_jump;
    logic        ex_mdu_start;
    logic        mdu_done;
    logic [3:0]  ex_fwd_sel;
    logic        stall_f, stall_d, stall_e, flush_d, flush_e, bubble_m;
    logic [5:0]  ctl;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_ctrl #(
        .NUM_SRC    (2),
        .FWD_STAGES (2),
        .LOAD_LAT   (2),
        .RA_W       (5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs_addr   (id_rs_addr),
        .id_rs_ren    (id_rs_ren),
        .fwd_rd_addr  (fwd_rd_addr),
        .fwd_rd_wen   (fwd_rd_wen),
        .ex_is_load   (ex_is_load),
        .ex_jump      (ex_jump),
        .ex_mdu_start (ex_mdu_start),
        .mdu_done     (mdu_done),
        .ex_fwd_sel   (ex_fwd_sel),
        .stall_f      (stall_f),
        .stall_d      (stall_d),
        .stall_e      (stall_e),
        .flush_d      (flush_d),
        .flush_e      (flush_e),
        .bubble_m     (bubble_m)
    );

    // {stall_f, stall_d, stall_e, flush_d, flush_e, bubble_m}
    assign ctl = {stall_f, stall_d, stall_e, flush_d, flush_e, bubble_m};

    localparam logic [5:0] C_NONE = 6'b000000;
    localparam logic [5:0] C_LDU  = 6'b110010;
    localparam logic [5:0] C_JMP  = 6'b000110;
    localparam logic [5:0] C_MDU  = 6'b111001;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [4:0] rs0, input logic [4:0] rs1, input logic [1:0] ren,
                       input logic [4:0] rd0, input logic [4:0] rd1, input logic [1:0] wen,
                       input logic ld, input logic jp, input logic ms, input logic md);
        id_rs_addr   = {rs1, rs0};
        id_rs_ren    = ren;
        fwd_rd_addr  = {rd1, rd0};
        fwd_rd_wen   = wen;
        ex_is_load   = ld;
        ex_jump      = jp;
        ex_mdu_start = ms;
        mdu_done     = md;
    endtask

    task automatic idle();
        drv(5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Control outputs mid-cycle, then the select registered at the next edge.
    task automatic step(input string tag, input logic [5:0] ctl_exp, input logic [3:0] sel_exp);
        @(negedge clk);
        check({tag, "_ctl"}, 32'(ctl), 32'(ctl_exp));
        tick();
        check({tag, "_sel"}, 32'(ex_fwd_sel), 32'(sel_exp));
    endtask

    initial begin
        rst = 1'b1;
        // Load-use pattern present during and right after reset: must stay quiet.
        drv(5'd3, 5'd0, 2'b01, 5'd3, 5'd0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("rst_ctl", 32'(ctl), 32'(C_NONE));
        tick();
        check("rst_sel", 32'(ex_fwd_sel), 32'h0);
        rst = 1'b0;
        step("post_rst", C_NONE, 4'b0001);

        idle();
        step("idle", C_NONE, 4'b0000);

        // Back-to-back ALU dependency on src0.
        drv(5'd5, 5'd0, 2'b01, 5'd5, 5'd0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        step("b2b", C_NONE, 4'b0001);

        // Both stages write r7, src1 reads r7: youngest (stage 0) wins.
        drv(5'd2, 5'd7, 2'b11, 5'd7, 5'd7, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        step("prio", C_NONE, 4'b0100);

        // x0 never matches, even for a load in E.
        drv(5'd0, 5'd0, 2'b11, 5'd0, 5'd0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
        step("x0", C_NONE, 4'b0000);

        // Only stage 1 writes r9.
        drv(5'd9, 5'd0, 2'b01, 5'd9, 5'd9, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        step("stg1", C_NONE, 4'b0010);

        // Read enable off: no match, no load-use.
        drv(5'd0, 5'd7, 2'b00, 5'd7, 5'd0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        step("ren_off", C_NONE, 4'b0000);

        // Load-use: two bubble cycles, then forward from stage 1.
        drv(5'd3, 5'd0, 2'b01, 5'd3, 5'd0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        step("ldu_a", C_LDU, 4'b0000);
        drv(5'd3, 5'd0, 2'b01, 5'd0, 5'd3, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        step("ldu_b", C_LDU, 4'b0000);
        step("ldu_post", C_NONE, 4'b0010);
        idle();
        step("ldu_idle", C_NONE, 4'b0000);

        // Jump during LD_WAIT (load-use on src1).
        drv(5'd0, 5'd4, 2'b10, 5'd4, 5'd0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        step("jld_a", C_LDU, 4'b0000);
        drv(5'd0, 5'd4, 2'b10, 5'd0, 5'd4, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0);
        step("jld_jmp", C_JMP, 4'b0000);
        idle();
        step("jld_run", C_NONE, 4'b0000);

        // Redirect beats load-use in RUN.
        drv(5'd6, 5'd0, 2'b01, 5'd6, 5'd0, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
        step("jrun", C_JMP, 4'b0000);
        idle();
        step("jrun_after", C_NONE, 4'b0000);

        // Reset in the middle of LD_WAIT leaves no residual stall.
        drv(5'd3, 5'd0, 2'b01, 5'd3, 5'd0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        step("ldr_a", C_LDU, 4'b0000);
        rst = 1'b1;
        idle();
        step("ldr_rst", C_NONE, 4'b0000);
        rst = 1'b0;
        step("ldr_after", C_NONE, 4'b0000);
        drv(5'd3, 5'd0, 2'b01, 5'd3, 5'd0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        step("ldr_again", C_LDU, 4'b0000);
        idle();
        step("ldr_wait", C_LDU, 4'b0000);
        step("ldr_done", C_NONE, 4'b0000);

`ifdef HAZARD_MDU_EN
        // MDU op, done four cycles after start: four held cycles.
        drv(5'd5, 5'd0, 2'b01, 5'd5, 5'd0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        step("mdu_pre", C_NONE, 4'b0001);
        drv(5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        step("mdu_s", C_MDU, 4'b0001);
        for (int i = 0; i < 3; i++) begin
            step("mdu_w", C_MDU, 4'b0001);
        end
        drv(5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        step("mdu_done", C_NONE, 4'b0000);
        step("mdu_zero", C_NONE, 4'b0000);
        // Jump ignored while waiting on the MDU.
        drv(5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        step("mdj_s", C_MDU, 4'b0000);
        drv(5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
        step("mdj_jmp", C_MDU, 4'b0000);
        drv(5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        step("mdu6_w2", C_MDU, 4'b0000);
        // Reset in a later MDU_WAIT cycle.
        rst = 1'b1;
        step("mdu6_rst", C_NONE, 4'b0000);
        rst = 1'b0;
        idle();
        step("mdu6_after", C_NONE, 4'b0000);
        drv(5'd5, 5'd0, 2'b01, 5'd5, 5'd0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        step("mdu6_plain", C_NONE, 4'b0001);
`else
        // Without MDU support the MDU inputs are ignored.
        drv(5'd5, 5'd0, 2'b01, 5'd5, 5'd0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
        step("nomdu_s", C_NONE, 4'b0001);
        idle();
        ex_mdu_start = 1'b1;
        step("nomdu_w", C_NONE, 4'b0000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
